// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - load-use hazard scoreboard for variable-latency loads
module load_use_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int REG_AW          = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3,
  parameter int BYPASS_DONE     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_is_load,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic [REG_AW-1:0]   issue_rs1,
  input  logic                issue_rs1_used,
  input  logic [REG_AW-1:0]   issue_rs2,
  input  logic                issue_rs2_used,
  input  logic                load_done_valid,
  input  logic [REG_AW-1:0]   load_done_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    pending_count,
  output logic                full,
  output logic                err,
  output logic [31:0]         stall_cycles
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                done_byp;
  logic                pend_rs1, pend_rs2, pend_rd;
  logic                raw1, raw2, waw, cap;
  logic                accept_load;
  logic                done_err, done_ok;
  logic [NUM_REGS-1:0] mask_next;
  logic [CNT_W-1:0]    count_next;

  assign full     = (pending_count == MAX_CNT);
  assign done_byp = (BYPASS_DONE != 0) && load_done_valid;

  // A register being written back this cycle no longer blocks when bypass is enabled.
  assign pend_rs1 = pending_mask[issue_rs1] && !(done_byp && load_done_rd == issue_rs1);
  assign pend_rs2 = pending_mask[issue_rs2] && !(done_byp && load_done_rd == issue_rs2);
  assign pend_rd  = pending_mask[issue_rd]  && !(done_byp && load_done_rd == issue_rd);

  assign raw1  = issue_rs1_used && (issue_rs1 != '0) && pend_rs1;
  assign raw2  = issue_rs2_used && (issue_rs2 != '0) && pend_rs2;
  assign waw   = (issue_rd != '0) && pend_rd;
  assign cap   = issue_is_load && full && !done_byp;
  assign stall = issue_valid && (raw1 || raw2 || waw || cap);

  assign accept_load = issue_valid && !stall && issue_is_load;

  assign done_err = load_done_valid &&
                    ((pending_count == '0) ||
                     ((load_done_rd != '0) && !pending_mask[load_done_rd]));
  assign done_ok  = load_done_valid && !done_err;

  // Clear before set so a same-register issue and completion leaves the bit set.
  always_comb begin
    mask_next = pending_mask;
    if (done_ok)
      mask_next[load_done_rd] = 1'b0;
    if (accept_load && issue_rd != '0)
      mask_next[issue_rd] = 1'b1;
    mask_next[0] = 1'b0;
  end

  always_comb begin
    count_next = pending_count;
    if (accept_load && !done_ok && pending_count != MAX_CNT)
      count_next = pending_count + 1'b1;
    else if (!accept_load && done_ok && pending_count != '0)
      count_next = pending_count - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_mask  <= '0;
      pending_count <= '0;
      err           <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      pending_mask  <= mask_next;
      pending_count <= count_next;
      if (done_err)
        err <= 1'b1;
      if (stall)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Generalised load-use hazard unit for the 5-stage RISC-V pipeline.
- Supports variable-latency data memory and up to MAX_OUTSTANDING in-flight loads, replacing the fixed one-bubble load-use stall.
- Sits between ID and EX. Tracks pending load destinations per architectural register and stalls IF/ID on RAW, WAW or capacity hazards until the load writes back.

Parameters:
- NUM_REGS, 32, number of architectural registers (x0 hardwired zero).
- REG_AW, 5, register index width; equals clog2(NUM_REGS).
- MAX_OUTSTANDING, 4, maximum loads issued but not yet written back; minimum 1.
- CNT_W, 3, pending counter width; equals clog2(MAX_OUTSTANDING+1).
- BYPASS_DONE, 1, when 1 a same-cycle writeback of a register clears its hazard combinationally.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- issue_valid, in, 1, ID holds a valid instruction requesting entry to EX.
- issue_is_load, in, 1, that instruction is a load.
- issue_rd, in, REG_AW, destination register.
- issue_rs1, in, REG_AW, source 1.
- issue_rs1_used, in, 1, source 1 is read.
- issue_rs2, in, REG_AW, source 2.
- issue_rs2_used, in, 1, source 2 is read.
- load_done_valid, in, 1, a load writes back this cycle.
- load_done_rd, in, REG_AW, destination of the completing load.
- stall, out, 1, hold PC and IF/ID; insert bubble into ID/EX.
- pending_mask, out, NUM_REGS, registered scoreboard bits; bit 0 always 0.
- pending_count, out, CNT_W, registered count of outstanding loads.
- full, out, 1, pending_count == MAX_OUTSTANDING.
- err, out, 1, sticky protocol error.
- stall_cycles, out, 32, count of cycles with stall=1.

Behaviour:
- Reset (synchronous, any cycle, including mid-operation):
  - pending_mask=0, pending_count=0, err=0, stall_cycles=0.
  - All in-flight state is discarded; load_done pulses in the reset cycle are ignored.
- Stall is combinational: stall = issue_valid & (raw1 | raw2 | waw | cap).
  - raw1: issue_rs1_used & rs1!=0 & pend(rs1).
  - raw2: issue_rs2_used & rs2!=0 & pend(rs2).
  - waw: rd!=0 & pend(rd). Applies to any instruction with a valid rd; a non-load caller drives rd=0 if it writes no register.
  - cap: issue_is_load & full & !(load_done_valid when BYPASS_DONE=1).
  - pend(r) = pending_mask[r] & !(BYPASS_DONE & load_done_valid & load_done_rd==r).
- Accepted issue: issue_valid & !stall. Scoreboard updates at the next rising edge:
  - Accepted load with rd!=0 sets pending_mask[rd].
  - Accepted load with rd==0 sets no bit but still increments pending_count; its completion must use load_done_rd=0.
  - load_done_valid clears pending_mask[load_done_rd] (bit 0 never set) and decrements pending_count.
- Simultaneous events:
  - Accepted load and done in the same cycle: count unchanged.
  - Same rd for both: bit ends set (set wins). This is only reachable via bypass, since waw otherwise stalls.
- Protocol error: err sets (sticky until reset) when load_done_valid occurs with pending_count==0, or with load_done_rd!=0 and pending_mask[load_done_rd]==0. On error the count and mask are left unchanged for that event.
- Count arithmetic saturates: never below 0; never above MAX_OUTSTANDING, since cap prevents issue.
- stall_cycles increments by 1 per cycle with stall=1 and wraps at 2^32.
- Latency:
  - Hazard detection has zero cycles of latency.
  - Scoreboard, count and full become visible one cycle after the event.

Test Plan:
- lw x1 issued at cycle 0, add x2,x1,x1 presented at cycle 1, load_done rd=1 at cycle 4 -> stall=1 for cycles 1-3 (or 1-4 with BYPASS_DONE=0); add accepted at cycle 4 (or 5); stall_cycles=3 (or 4); pending_mask[1]=0 afterwards.
- Four loads to x3,x4,x5,x6 back-to-back with MAX_OUTSTANDING=4, fifth load to x7 -> full=1, pending_count=4; fifth load stalls until one done arrives, then is accepted the same cycle (bypass).
- lw x0 followed by add x8,x0,x0 -> no stall; pending_count=1, pending_mask=0; done rd=0 -> pending_count=0, err=0.
- Load done rd=9 with pending_mask[9]=0, then a separate done with count=0 -> err=1 and stays 1; count and mask unchanged.
- Two loads pending (x1,x2), reset asserted for 1 cycle -> next cycle mask=0, count=0, stall=0 for add x3,x1,x2; done pulse during reset has no effect.
- Pending load to x5, sw x5 issued with rs2_used=1 and done rd=5 in the same cycle -> stall=0 with BYPASS_DONE=1, stall=1 with BYPASS_DONE=0.
